// File: rtl/rf_scoreboard_pkg.sv
// Shared scoreboard constants and types.
// Latency encodings count pipe advances until a result can be bypassed.
package rf_scoreboard_pkg;

   localparam int NREG         = 32;
   localparam int MAX_INFLIGHT = 3;
   localparam int RW           = 5;

   typedef logic [RW-1:0] reg_t;

   typedef enum logic [1:0] {
      LAT_EXE = 2'd0,
      LAT_MEM = 2'd1,
      LAT_WB  = 2'd2
   } lat_e;

endpackage

// File: rtl/rf_scoreboard_if.sv
// ID-side issue, WB-side commit and status bundle for the scoreboard.
// master is the ID/WB side, slave is the scoreboard.
interface rf_scoreboard_if
   import rf_scoreboard_pkg::*;
#(
   parameter int N = rf_scoreboard_pkg::NREG
) ();

   logic         iss_valid;
   logic         iss_ready;
   reg_t         iss_rs1;
   reg_t         iss_rs2;
   logic         iss_rs1_en;
   logic         iss_rs2_en;
   logic         iss_rf_we;
   reg_t         iss_rd;
   logic [1:0]   iss_rdy_lat;
   logic         pipe_adv;
   logic         wb_valid;
   logic         wb_we;
   reg_t         wb_rd;
   logic         flush;
   logic         src1_ready;
   logic         src2_ready;
   logic [N-1:0] busy_vec;
   logic         sb_err;

   modport master (
      output iss_valid, iss_rs1, iss_rs2,
      output iss_rs1_en, iss_rs2_en,
      output iss_rf_we, iss_rd, iss_rdy_lat,
      output pipe_adv, wb_valid, wb_we, wb_rd,
      output flush,
      input  iss_ready, src1_ready, src2_ready,
      input  busy_vec, sb_err
   );

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2,
      input  iss_rs1_en, iss_rs2_en,
      input  iss_rf_we, iss_rd, iss_rdy_lat,
      input  pipe_adv, wb_valid, wb_we, wb_rd,
      input  flush,
      output iss_ready, src1_ready, src2_ready,
      output busy_vec, sb_err
   );

endinterface

// File: rtl/rf_scoreboard_sb_entry.sv
// One register's writer count and youngest-writer latency countdown.
// flush beats fire/retire; a latency load beats the advance decrement.
module rf_scoreboard_sb_entry (
   input  logic       clk,
   input  logic       reset,
   input  logic       fire_i,
   input  logic [1:0] rdy_lat_i,
   input  logic       adv_i,
   input  logic       retire_i,
   input  logic       flush_i,
   output logic [1:0] cnt_o,
   output logic [1:0] lat_o,
   output logic       err_o
);

   logic [1:0] cnt_q, cnt_d;
   logic [1:0] lat_q, lat_d;

   always_comb begin
      cnt_d = cnt_q;
      lat_d = lat_q;
      err_o = 1'b0;
      if (flush_i) begin
         cnt_d = '0;
         lat_d = '0;
      end else begin
         err_o = retire_i && (cnt_q == 2'd0);
         unique case ({fire_i, retire_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
         if (fire_i)
            lat_d = rdy_lat_i;
         else if (adv_i && lat_q != 2'd0)
            lat_d = lat_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         lat_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lat_q <= lat_d;
      end
   end

   assign cnt_o = cnt_q;
   assign lat_o = lat_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard gating ID issue on operand readiness.
// Build with SB_PERF_EN to add the stall_cnt stall-cycle counter port.
module rf_scoreboard
   import rf_scoreboard_pkg::*;
#(
   parameter int NREG         = rf_scoreboard_pkg::NREG,
   parameter int MAX_INFLIGHT = rf_scoreboard_pkg::MAX_INFLIGHT
) (
   input  logic clk,
   input  logic reset,
   rf_scoreboard_if.slave sb
`ifdef SB_PERF_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic [1:0]      cnt [NREG];
   logic [1:0]      lat [NREG];
   logic [NREG-1:1] fire_v;
   logic [NREG-1:1] ret_v;
   logic [NREG-1:1] err_v;
   logic [NREG-1:0] busy;
   logic            s1_rdy, s2_rdy, rd_full;
   logic            iss_rdy, fire, retire;
   logic            sb_err_q, sb_err_d;

   assign cnt[0] = '0;
   assign lat[0] = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_ent
      rf_scoreboard_sb_entry u_ent (
         .clk       (clk),
         .reset     (reset),
         .fire_i    (fire_v[r]),
         .rdy_lat_i (sb.iss_rdy_lat),
         .adv_i     (sb.pipe_adv),
         .retire_i  (ret_v[r]),
         .flush_i   (sb.flush),
         .cnt_o     (cnt[r]),
         .lat_o     (lat[r]),
         .err_o     (err_v[r])
      );
   end

   // Readiness only looks at registered state; same-cycle WB never helps.
   assign s1_rdy = !sb.iss_rs1_en || sb.iss_rs1 == '0 ||
                   cnt[sb.iss_rs1] == 2'd0 ||
                   lat[sb.iss_rs1] == 2'd0;
   assign s2_rdy = !sb.iss_rs2_en || sb.iss_rs2 == '0 ||
                   cnt[sb.iss_rs2] == 2'd0 ||
                   lat[sb.iss_rs2] == 2'd0;
   assign rd_full = sb.iss_rf_we && sb.iss_rd != '0 &&
                    cnt[sb.iss_rd] == 2'(MAX_INFLIGHT);
   assign iss_rdy = s1_rdy && s2_rdy && !rd_full;

   assign fire   = sb.iss_valid && iss_rdy &&
                   sb.iss_rf_we && sb.iss_rd != '0;
   assign retire = sb.wb_valid && sb.wb_we && sb.wb_rd != '0;

   always_comb begin
      fire_v = '0;
      ret_v  = '0;
      busy   = '0;
      for (int r = 1; r < NREG; r++) begin
         fire_v[r] = fire && (sb.iss_rd == RW'(r));
         ret_v[r]  = retire && (sb.wb_rd == RW'(r));
         busy[r]   = cnt[r] != 2'd0;
      end
   end

   assign sb_err_d = sb_err_q || (|err_v);

   always_ff @(posedge clk) begin
      if (reset) sb_err_q <= 1'b0;
      else       sb_err_q <= sb_err_d;
   end

`ifdef SB_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (sb.iss_valid && !iss_rdy && !sb.flush)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

   assign sb.iss_ready  = iss_rdy;
   assign sb.src1_ready = s1_rdy;
   assign sb.src2_ready = s2_rdy;
   assign sb.busy_vec   = busy;
   assign sb.sb_err     = sb_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scenario bench for rf_scoreboard with a per-register writer-list model.
// Define SB_PERF_EN to also exercise the stall counter.
module tb_rf_scoreboard;
   import rf_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rf_scoreboard_if bus ();
`ifdef SB_PERF_EN
   logic [31:0] stall_cnt;
`endif

   rf_scoreboard dut (
      .clk       (clk),
      .reset     (reset),
      .sb        (bus)
`ifdef SB_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   int n_cmp = 0;
   int n_fail = 0;

   // model: each register keeps an ordered list of in-flight writers'
   // remaining latencies (oldest first, youngest last)
   int wn [32];
   int wl [32][3];
   bit m_err;
`ifdef SB_PERF_EN
   int unsigned m_stall;
`endif

   function automatic bit m_src(bit en, logic [4:0] rs);
      if (!en || rs == 0 || wn[rs] == 0) return 1'b1;
      return wl[rs][wn[rs]-1] == 0;
   endfunction

   function automatic bit m_iss();
      return m_src(bus.iss_rs1_en, bus.iss_rs1) &&
             m_src(bus.iss_rs2_en, bus.iss_rs2) &&
             !(bus.iss_rf_we && bus.iss_rd != 0 &&
               wn[bus.iss_rd] == MAX_INFLIGHT);
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int r = 0; r < 32; r++) b[r] = wn[r] != 0;
      return b;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 32; r++) wn[r] = 0;
   endtask

   task automatic m_update();
      bit f, rt;
      int d;
      f  = bus.iss_valid && m_iss() && bus.iss_rf_we && bus.iss_rd != 0;
      rt = bus.wb_valid && bus.wb_we && bus.wb_rd != 0;
      if (reset) begin
         m_clear();
         m_err = 0;
`ifdef SB_PERF_EN
         m_stall = 0;
`endif
         return;
      end
`ifdef SB_PERF_EN
      if (bus.iss_valid && !m_iss() && !bus.flush) m_stall++;
`endif
      if (bus.flush) begin
         m_clear();
         return;
      end
      if (bus.pipe_adv)
         for (int r = 0; r < 32; r++)
            for (int k = 0; k < wn[r]; k++)
               if (wl[r][k] > 0) wl[r][k]--;
      if (rt) begin
         d = int'(bus.wb_rd);
         if (wn[d] == 0) m_err = 1;
         else begin
            for (int k = 0; k < 2; k++) wl[d][k] = wl[d][k+1];
            wn[d]--;
         end
      end
      if (f) begin
         d = int'(bus.iss_rd);
         wl[d][wn[d]] = int'(bus.iss_rdy_lat);
         wn[d]++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic idle();
      bus.iss_valid   = 0;
      bus.iss_rs1     = '0;
      bus.iss_rs2     = '0;
      bus.iss_rs1_en  = 0;
      bus.iss_rs2_en  = 0;
      bus.iss_rf_we   = 0;
      bus.iss_rd      = '0;
      bus.iss_rdy_lat = '0;
      bus.pipe_adv    = 0;
      bus.wb_valid    = 0;
      bus.wb_we       = 0;
      bus.wb_rd       = '0;
      bus.flush       = 0;
   endtask

   task automatic issue(int rd, lat_e l);
      idle();
      bus.iss_valid   = 1;
      bus.iss_rf_we   = 1;
      bus.iss_rd      = 5'(rd);
      bus.iss_rdy_lat = l;
   endtask

   task automatic commit(int rd);
      idle();
      bus.wb_valid = 1;
      bus.wb_we    = 1;
      bus.wb_rd    = 5'(rd);
   endtask

   task automatic test_reset();
      reset = 1;
      idle();
      bus.iss_valid = 1;
      bus.iss_rf_we = 1;
      bus.iss_rd    = 5'($urandom_range(1, 31));
      tick();
      tick();
      reset = 0;
      bus.iss_rs1    = 5'($urandom_range(1, 31));
      bus.iss_rs2    = 5'($urandom_range(1, 31));
      bus.iss_rs1_en = 1;
      bus.iss_rs2_en = 1;
      bus.iss_valid  = 0;
      #1;
      n_cmp += 5;
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_iss_ready got %b exp 1", bus.iss_ready);
      end
      if (bus.src1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_src1 got %b exp 1", bus.src1_ready);
      end
      if (bus.src2_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_src2 got %b exp 1", bus.src2_ready);
      end
      if (bus.busy_vec !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_busy got %h exp 0", bus.busy_vec);
      end
      if (bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_err got %b exp 0", bus.sb_err);
      end
`ifdef SB_PERF_EN
      n_cmp++;
      if (stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_stall got %0d exp 0", stall_cnt);
      end
`endif
   endtask

   task automatic test_add_bypass();
      issue(5, LAT_EXE);
      tick();
      issue(6, LAT_EXE);
      bus.iss_rs1    = 5'd5;
      bus.iss_rs1_en = 1;
      #1;
      n_cmp += 3;
      if (bus.src1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL add_src1 got %b exp 1", bus.src1_ready);
      end
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL add_ready got %b exp 1", bus.iss_ready);
      end
      if (bus.busy_vec[5] !== 1'b1) begin
         n_fail++;
         $display("FAIL add_busy got %b exp 1", bus.busy_vec[5]);
      end
      tick();
      commit(5);
      #1;
      n_cmp++;
      if (bus.busy_vec[5] !== 1'b1) begin
         n_fail++;
         $display("FAIL add_busy_wb got %b exp 1", bus.busy_vec[5]);
      end
      tick();
      commit(6);
      #1;
      n_cmp++;
      if (bus.busy_vec[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL add_busy_ret got %b exp 0", bus.busy_vec[5]);
      end
      tick();
   endtask

   task automatic test_load_use();
      issue(7, LAT_MEM);
      bus.pipe_adv = 1;
      tick();
      idle();
      bus.iss_valid  = 1;
      bus.iss_rs2    = 5'd7;
      bus.iss_rs2_en = 1;
      #1;
      n_cmp++;
      if (bus.iss_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_stall got %b exp 0", bus.iss_ready);
      end
      tick();
      #1;
      n_cmp++;
      if (bus.iss_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_freeze got %b exp 0", bus.iss_ready);
      end
      bus.pipe_adv = 1;
      tick();
      bus.pipe_adv = 0;
      #1;
      n_cmp += 2;
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_go got %b exp 1", bus.iss_ready);
      end
      if (bus.src2_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_src2 got %b exp 1", bus.src2_ready);
      end
      commit(7);
      tick();
   endtask

   task automatic test_max_inflight();
      for (int i = 0; i < 3; i++) begin
         issue(3, LAT_EXE);
         tick();
      end
      issue(3, LAT_EXE);
      #1;
      n_cmp++;
      if (bus.iss_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_stall got %b exp 0", bus.iss_ready);
      end
      bus.wb_valid = 1;
      bus.wb_we    = 1;
      bus.wb_rd    = 5'd3;
      #1;
      n_cmp++;
      if (bus.iss_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_wb_same got %b exp 0", bus.iss_ready);
      end
      tick();
      bus.wb_valid = 0;
      #1;
      n_cmp++;
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_go got %b exp 1", bus.iss_ready);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         commit(3);
         tick();
      end
      idle();
      #1;
      n_cmp++;
      if (bus.busy_vec[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL full_drain got %b exp 0", bus.busy_vec[3]);
      end
   endtask

   task automatic test_fire_retire();
      issue(4, LAT_EXE);
      tick();
      issue(4, LAT_WB);
      bus.wb_valid = 1;
      bus.wb_we    = 1;
      bus.wb_rd    = 5'd4;
      tick();
      idle();
      bus.iss_valid  = 1;
      bus.iss_rs1    = 5'd4;
      bus.iss_rs1_en = 1;
      #1;
      n_cmp += 2;
      if (bus.busy_vec[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL fr_busy got %b exp 1", bus.busy_vec[4]);
      end
      if (bus.src1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fr_lat2 got %b exp 0", bus.src1_ready);
      end
      bus.pipe_adv = 1;
      tick();
      n_cmp++;
      if (bus.src1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fr_lat1 got %b exp 0", bus.src1_ready);
      end
      tick();
      n_cmp++;
      if (bus.src1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fr_lat0 got %b exp 1", bus.src1_ready);
      end
      commit(4);
      tick();
      idle();
      #1;
      n_cmp += 2;
      if (bus.busy_vec[4] !== 1'b0) begin
         n_fail++;
         $display("FAIL fr_cnt1 got %b exp 0", bus.busy_vec[4]);
      end
      if (bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL fr_err got %b exp 0", bus.sb_err);
      end
   endtask

   task automatic test_flush_err();
      issue(2, LAT_EXE);
      tick();
      issue(9, LAT_WB);
      tick();
      idle();
      #1;
      n_cmp++;
      if (bus.busy_vec !== 32'h0000_0204) begin
         n_fail++;
         $display("FAIL fl_busy got %h exp 00000204", bus.busy_vec);
      end
      issue(10, LAT_EXE);
      bus.flush = 1;
      tick();
      idle();
      bus.iss_valid  = 1;
      bus.iss_rs1    = 5'd9;
      bus.iss_rs1_en = 1;
      #1;
      n_cmp += 2;
      if (bus.busy_vec !== 32'h0) begin
         n_fail++;
         $display("FAIL fl_clear got %h exp 0", bus.busy_vec);
      end
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fl_ready got %b exp 1", bus.iss_ready);
      end
      commit(2);
      tick();
      idle();
      #1;
      n_cmp++;
      if (bus.sb_err !== 1'b1) begin
         n_fail++;
         $display("FAIL fl_err got %b exp 1", bus.sb_err);
      end
      bus.flush = 1;
      tick();
      bus.flush = 0;
      tick();
      n_cmp++;
      if (bus.sb_err !== 1'b1) begin
         n_fail++;
         $display("FAIL fl_sticky got %b exp 1", bus.sb_err);
      end
   endtask

   task automatic test_r0();
      issue(0, LAT_WB);
      bus.iss_rs1_en = 1;
      bus.iss_rs2_en = 1;
      #1;
      n_cmp += 3;
      if (bus.iss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL r0_ready got %b exp 1", bus.iss_ready);
      end
      if (bus.src1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL r0_src1 got %b exp 1", bus.src1_ready);
      end
      if (bus.src2_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL r0_src2 got %b exp 1", bus.src2_ready);
      end
      tick();
      n_cmp++;
      if (bus.busy_vec !== 32'h0) begin
         n_fail++;
         $display("FAIL r0_busy got %h exp 0", bus.busy_vec);
      end
   endtask

   task automatic test_reset_mid();
      issue(11, LAT_WB);
      tick();
      issue(12, LAT_MEM);
      bus.wb_valid = 1;
      bus.wb_we    = 1;
      bus.wb_rd    = 5'd20;
      reset = 1;
      tick();
      reset = 0;
      idle();
      #1;
      n_cmp += 2;
      if (bus.busy_vec !== 32'h0) begin
         n_fail++;
         $display("FAIL rm_busy got %h exp 0", bus.busy_vec);
      end
      if (bus.sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_err got %b exp 0", bus.sb_err);
      end
   endtask

`ifdef SB_PERF_EN
   task automatic test_perf();
      logic [31:0] s0;
      s0 = stall_cnt;
      issue(13, LAT_WB);
      tick();
      idle();
      bus.iss_valid  = 1;
      bus.iss_rs1    = 5'd13;
      bus.iss_rs1_en = 1;
      for (int i = 0; i < 4; i++) tick();
      idle();
      #1;
      n_cmp++;
      if (stall_cnt - s0 !== 32'd4) begin
         n_fail++;
         $display("FAIL perf_stall got %0d exp 4", stall_cnt - s0);
      end
      commit(13);
      tick();
   endtask
`endif

   task automatic test_random();
      int pick;
      reset = 1;
      idle();
      tick();
      reset = 0;
      for (int c = 0; c < 800; c++) begin
         idle();
         bus.iss_valid   = 1'($urandom_range(0, 1));
         bus.iss_rs1     = 5'($urandom_range(0, 7));
         bus.iss_rs2     = 5'($urandom_range(0, 7));
         bus.iss_rs1_en  = 1'($urandom_range(0, 1));
         bus.iss_rs2_en  = 1'($urandom_range(0, 1));
         bus.iss_rf_we   = ($urandom_range(0, 3) != 0);
         bus.iss_rd      = 5'($urandom_range(0, 7));
         bus.iss_rdy_lat = 2'($urandom_range(0, 2));
         bus.pipe_adv    = ($urandom_range(0, 9) < 7);
         bus.flush       = ($urandom_range(0, 49) == 0);
         pick = -1;
         for (int k = 0; k < 7; k++)
            if (pick < 0 && wn[1 + (c + k) % 7] != 0) pick = 1 + (c + k) % 7;
         if (pick > 0 && $urandom_range(0, 9) < 4) begin
            bus.wb_valid = 1;
            bus.wb_we    = ($urandom_range(0, 7) != 0);
            bus.wb_rd    = 5'(pick);
         end
         #1;
         n_cmp += 5;
         if (bus.iss_ready !== m_iss()) begin
            n_fail++;
            $display("FAIL rnd_ready c=%0d got %b exp %b",
                     c, bus.iss_ready, m_iss());
         end
         if (bus.src1_ready !== m_src(bus.iss_rs1_en, bus.iss_rs1)) begin
            n_fail++;
            $display("FAIL rnd_src1 c=%0d got %b", c, bus.src1_ready);
         end
         if (bus.src2_ready !== m_src(bus.iss_rs2_en, bus.iss_rs2)) begin
            n_fail++;
            $display("FAIL rnd_src2 c=%0d got %b", c, bus.src2_ready);
         end
         if (bus.busy_vec !== m_busy()) begin
            n_fail++;
            $display("FAIL rnd_busy c=%0d got %h exp %h",
                     c, bus.busy_vec, m_busy());
         end
         if (bus.sb_err !== m_err) begin
            n_fail++;
            $display("FAIL rnd_err c=%0d got %b exp %b", c, bus.sb_err, m_err);
         end
`ifdef SB_PERF_EN
         n_cmp++;
         if (stall_cnt !== m_stall) begin
            n_fail++;
            $display("FAIL rnd_stall c=%0d got %0d exp %0d",
                     c, stall_cnt, m_stall);
         end
`endif
         tick();
      end
   endtask

   initial begin
      m_clear();
      m_err = 0;
`ifdef SB_PERF_EN
      m_stall = 0;
`endif
      reset = 1;
      idle();
      test_reset();
      test_add_bypass();
      test_load_use();
      test_max_inflight();
      test_fire_retire();
      test_flush_err();
      test_r0();
      test_reset_mid();
`ifdef SB_PERF_EN
      test_perf();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file scoreboard that sequences operand readiness for the decode/issue stage. It tracks, per architectural register, how many in-flight instructions beyond ID will write it and how many pipeline advances remain before the youngest writer's result becomes bypassable. From this it drives the ID stage's ready/stall decision. It sits beside the ID stage: it updates on issue to EXE, decrements on pipeline advance, and releases on WB commit.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- MAX_INFLIGHT, 3, maximum outstanding writers per register (EXE, MEM, WB).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- iss_valid  in  1  ID holds a valid instruction
- iss_ready  out  1  scoreboard permits issue this cycle
- iss_rs1, iss_rs2  in  5 each  source register numbers
- iss_rs1_en, iss_rs2_en  in  1 each  the source is read from the register file
- iss_rf_we  in  1  instruction writes a register
- iss_rd  in  5  destination register
- iss_rdy_lat  in  2  pipeline advances after issue before the result is bypassable (0 = EXE, 1 = MEM, 2 = WB)
- pipe_adv  in  1  EXE/MEM/WB advanced this cycle
- wb_valid, wb_we  in  1 each  WB commits a register write
- wb_rd  in  5  committed destination
- flush  in  1  kill all in-flight state (exception/refetch)
- src1_ready, src2_ready  out  1 each  per-source readiness
- busy_vec  out  NREG  registered bit per register, set when its count is nonzero
- sb_err  out  1  sticky protocol error
- stall_cnt  out  32  only when SB_PERF_EN is defined

## Operation
- State per register r:
  - cnt[r], 2 bits: number of in-flight writers.
  - lat[r], 2 bits: remaining advances until the youngest writer's value is bypassable.
- srcN_ready = !srcN_en | rsN==0 | cnt[rsN]==0 | lat[rsN]==0. Purely combinational from registered state.
- iss_ready = src1_ready & src2_ready & !(iss_rf_we & iss_rd!=0 & cnt[iss_rd]==MAX_INFLIGHT).
- Issue fire = iss_valid & iss_ready & iss_rf_we & iss_rd!=0. On fire:
  - cnt[iss_rd] increments.
  - lat[iss_rd] loads iss_rdy_lat. The load overrides any same-cycle decrement.
- pipe_adv: every lat[r] with r not being loaded this cycle decrements, saturating at 0.
- Retire = wb_valid & wb_we & wb_rd!=0. On retire, cnt[wb_rd] decrements.
- Retire and fire on the same register in the same cycle: cnt is unchanged and lat loads.
- Retire while cnt==0: cnt holds at 0 and sb_err sets.
- Register 0 never updates; cnt[0]=lat[0]=0 always.
- flush: all cnt and lat clear to 0 next cycle. flush has priority over fire and retire in that cycle. sb_err is unaffected.
- sb_err clears only on reset.

## Timing
- Reset values:
  - all cnt, lat, busy_vec = 0
  - sb_err = 0
  - stall_cnt = 0
  - iss_ready = 1 and src*_ready = 1 for any inputs
- State written by fire or retire is visible one cycle later.
- A same-cycle WB retire does not combinationally raise readiness; lat must already be 0 for that.
- Load-use example with iss_rdy_lat=1: the consumer stalls exactly one pipe_adv cycle.
- If pipe_adv stays low, the lat countdown freezes and the consumer stays stalled.
- If reset arrives mid-operation, all state clears on that edge regardless of other inputs.

## Configuration
- SB_PERF_EN defined:
  - stall_cnt increments, wrapping at 2^32, on every cycle with iss_valid & !iss_ready & !flush.
- SB_PERF_EN undefined:
  - the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package/header (myCPU.h): NREG, MAX_INFLIGHT, latency encodings (LAT_EXE=0, LAT_MEM=1, LAT_WB=2).
- One sub-module, sb_entry: holds one register's cnt/lat with fire, adv, retire and flush inputs. It is instantiated NREG-1 times via generate. The top level holds decode and readiness muxing.

## Test plan
- Issue add r5 (lat 0), then next cycle a consumer reads r5 -> src1_ready=1 and iss_ready=1; busy_vec[5]=1 until WB retire, then 0.
- Issue ld.w r7 (lat 1), consumer of r7 next cycle with pipe_adv=1 -> iss_ready=0 for 1 cycle, then 1.
- Three writers to r3 outstanding (cnt=3), a fourth r3 write in ID -> iss_ready=0 until one WB retire, then 1.
- Same-cycle fire to r4 and retire of r4 with cnt=1 -> cnt stays 1 and lat[4] = new iss_rdy_lat.
- flush with r2 and r9 busy -> busy_vec=0 next cycle; retire of r2 afterwards -> sb_err=1 and stays 1.
- Reads of r0, and a write with rd=0 -> always ready and busy_vec[0]=0. With SB_PERF_EN, 4 stalled cycles -> stall_cnt=4.
